// File: rtl/ham_pkg.sv
// Shared definitions for the 7-bit Hamming codeword link.
// Used by the serializer, this deserializer and the decoder.
package ham_pkg;

  // Default codeword length carried on the serial link.
  localparam int CODE_W = 7;

  // Frame-receive state: no frame open, or a frame partially received.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } frame_state_e;

endpackage : ham_pkg

// File: rtl/sipo_frame_ctrl.sv
// Framing controller for the deserializer: tracks the open frame and counts its bits.
// Produces same-edge strobes (shift_en, load_out) for the datapath.
// Produces registered status (err, busy) that drives the top-level outputs directly.
module sipo_frame_ctrl
  import ham_pkg::*;
#(
  parameter int WIDTH = CODE_W,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic sof,
  output logic shift_en,
  output logic load_out,
  output logic err,
  output logic busy
);

  frame_state_e       state;
  logic [CNT_W-1:0]   cnt;
  logic               last_bit;

  // The bit accepted on this edge closes the frame when WIDTH-1 bits are already held.
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // busy comes straight from the state register, so it has no input-to-output path.
  assign busy = (state == SHIFT);

  // Decode this cycle's datapath strobes from the current state and inputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through it infers a latch.
    shift_en = 1'b0;
    load_out = 1'b0;
    unique case (state)
      IDLE: begin
        if (bit_valid && sof) begin
          shift_en = 1'b1;
          load_out = (WIDTH == 1);
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          shift_en = 1'b1;
          load_out = !sof && last_bit;
        end
      end
      default: ;
    endcase
  end

  // Frame FSM and bit counter; err is a registered one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      err <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          IDLE: begin
            if (sof) begin
              if (WIDTH == 1) begin
                cnt <= '0;
              end else begin
                state <= SHIFT;
                cnt   <= CNT_W'(1);
              end
            end
          end
          SHIFT: begin
            if (sof) begin
              // Restart: the partial frame is abandoned and this bit becomes bit 0.
              err <= 1'b1;
              cnt <= CNT_W'(1);
            end else if (last_bit) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule : sipo_frame_ctrl

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver for LSB-first codewords framed by a start-of-frame strobe.
// Presents each completed word with a one-cycle valid pulse.
module sipo_deserializer
  import ham_pkg::*;
#(
  parameter int WIDTH = CODE_W,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] parallel_out,
  output logic             word_valid,
  output logic             frame_err,
  output logic             busy
);

  logic             shift_en;
  logic             load_out;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] next_word;

  sipo_frame_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .sof       (sof),
    .shift_en  (shift_en),
    .load_out  (load_out),
    .err       (frame_err),
    .busy      (busy)
  );

  // New bits enter at the top, so after WIDTH shifts the first bit sits in bit 0.
  generate
    if (WIDTH == 1) begin : g_single
      assign next_word = serial_in;
    end else begin : g_multi
      assign next_word = {serial_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // Shift register plus the held output word and its valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg    <= '0;
      parallel_out <= '0;
      word_valid   <= 1'b0;
    end else begin
      word_valid <= load_out;
      if (shift_en) begin
        shift_reg <= next_word;
      end
      if (load_out) begin
        parallel_out <= next_word;
      end
    end
  end

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
// Directed self-checking bench for sipo_deserializer (WIDTH=7).
module tb_sipo_deserializer;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       bit_valid;
  logic       sof;
  logic [6:0] parallel_out;
  logic       word_valid;
  logic       frame_err;
  logic       busy;

  int n_pass;
  int n_total;
  logic [6:0] exp_par;

  sipo_deserializer #(
    .WIDTH (7),
    .CNT_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .bit_valid    (bit_valid),
    .sof          (sof),
    .parallel_out (parallel_out),
    .word_valid   (word_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Apply one input cycle on the falling edge; return 1 ns after the next rising edge.
  task automatic drive(input logic b, input logic v, input logic s);
    @(negedge clk);
    serial_in = b;
    bit_valid = v;
    sof       = s;
    @(posedge clk);
    #1;
  endtask

  // Send one framed word LSB first, optionally with an idle cycle before each bit after bit 0.
  // err0 is the frame_err value expected right after bit 0 (1 when it restarts an open frame).
  task automatic send_frame(input string tag, input logic [6:0] w, input bit gaps, input logic err0);
    for (int i = 0; i < 7; i++) begin
      if (gaps && i > 0) begin
        drive(1'b1, 1'b0, 1'b1);
        check({tag, " gap word_valid"}, 32'(word_valid), 32'd0);
        check({tag, " gap busy"}, 32'(busy), 32'd1);
      end
      drive(w[i], 1'b1, (i == 0));
      if (i < 6) begin
        check({tag, " mid word_valid"}, 32'(word_valid), 32'd0);
        check({tag, " mid busy"}, 32'(busy), 32'd1);
        check({tag, " mid parallel_out held"}, 32'(parallel_out), 32'(exp_par));
        check({tag, " mid frame_err"}, 32'(frame_err), (i == 0) ? 32'(err0) : 32'd0);
      end else begin
        exp_par = w;
        check({tag, " done word_valid"}, 32'(word_valid), 32'd1);
        check({tag, " done parallel_out"}, 32'(parallel_out), 32'(w));
        check({tag, " done frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " done busy"}, 32'(busy), 32'd0);
      end
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_par   = 7'h00;
    rst       = 1'b1;
    serial_in = 1'b0;
    bit_valid = 1'b0;
    sof       = 1'b0;
    #1;
    check("reset parallel_out", 32'(parallel_out), 32'd0);
    check("reset word_valid", 32'(word_valid), 32'd0);
    check("reset frame_err", 32'(frame_err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1) 7'h5A, bit_valid every cycle; pulse lasts exactly one cycle.
    send_frame("t1 5A", 7'h5A, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t1 word_valid one cycle", 32'(word_valid), 32'd0);
    check("t1 parallel_out holds", 32'(parallel_out), 32'h5A);

    // 2) Same word with idle cycles between bits.
    send_frame("t2 5A gaps", 7'h5A, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t2 word_valid drops", 32'(word_valid), 32'd0);

    // 3) Unframed bits in IDLE are dropped silently, then a framed 7'h7F.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check("t3 unframed busy", 32'(busy), 32'd0);
      check("t3 unframed frame_err", 32'(frame_err), 32'd0);
      check("t3 unframed word_valid", 32'(word_valid), 32'd0);
    end
    send_frame("t3 7F", 7'h7F, 1'b0, 1'b0);

    // 4) Four bits of a frame, then sof restarts it with 7'h25.
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    check("t4 partial busy", 32'(busy), 32'd1);
    check("t4 partial word_valid", 32'(word_valid), 32'd0);
    send_frame("t4 25", 7'h25, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t4 after frame_err", 32'(frame_err), 32'd0);

    // 5) Back-to-back 7'h12 and 7'h6D; the second pulse lands 7 cycles after the first.
    send_frame("t5 12", 7'h12, 1'b0, 1'b0);
    send_frame("t5 6D", 7'h6D, 1'b0, 1'b0);

    // 6) Reset three bits into a frame, then a framed 7'h01.
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("t6 pre-reset busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b0;
    sof       = 1'b0;
    #1;
    check("t6 reset parallel_out", 32'(parallel_out), 32'd0);
    check("t6 reset busy", 32'(busy), 32'd0);
    check("t6 reset word_valid", 32'(word_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t6 reset held parallel_out", 32'(parallel_out), 32'd0);
    check("t6 reset held frame_err", 32'(frame_err), 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    exp_par = 7'h00;
    send_frame("t6 01", 7'h01, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t6 final word_valid", 32'(word_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sipo_deserializer
